// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive controller.
// The parity-drop build option (UART_RX_CTRL_PERR_DROP_EN) is handled in uart_rx_ctrl.
package uart_pkg;

    localparam int UART_RX_FIFO_DEPTH_DEF    = 16;
    localparam int UART_RX_RTS_THRESHOLD_DEF = 12;

    // Receive handshake controller states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CAPTURE  = 2'd1,
        ACK      = 2'd2,
        WAIT_LOW = 2'd3
    } rx_ctrl_state_e;

    // One FIFO entry: parity flag in the MSB, character below it
    typedef struct packed {
        logic       perr;
        logic [7:0] data;
    } rx_entry_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous 9-bit receive FIFO. The caller gates push/pop, so both are
// trusted here; a push and a pop in the same cycle leave the level unchanged.
// Storage is not reset, only the pointers and the level.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH = UART_RX_FIFO_DEPTH_DEF,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  rx_entry_t     wdata,
    input  logic          pop,
    output rx_entry_t     rdata,
    output logic [LW-1:0] level,
    output logic          empty,
    output logic          full
);

    rx_entry_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    // Storage write; contents survive reset, which only loses them logically
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign empty = (level == '0);
    assign full  = (level == LW'(DEPTH));

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: takes frames from the receiver with a done/ack
// handshake, queues them in uart_rx_fifo, and drives overrun, RTS and IRQ.
// Define UART_RX_CTRL_PERR_DROP_EN to acknowledge but discard frames with a
// parity error (rd_perr_o then tied low).
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter  int FIFO_DEPTH    = UART_RX_FIFO_DEPTH_DEF,
    parameter  int RTS_THRESHOLD = UART_RX_RTS_THRESHOLD_DEF,
    localparam int LW            = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          rx_done_i,
    input  logic [7:0]    rx_data_i,
    input  logic          rx_parity_err_i,
    output logic          rx_ack_o,
    input  logic          rd_en_i,
    output logic [7:0]    rd_data_o,
    output logic          rd_perr_o,
    output logic [LW-1:0] level_o,
    output logic          empty_o,
    output logic          full_o,
    output logic          overrun_o,
    input  logic          clr_overrun_i,
    output logic          rts_n_o,
    output logic          irq_o
);

    rx_ctrl_state_e state_q, state_d;
    logic           accept_frame;
    logic           push;
    logic           pop;
    logic           overrun_set;
    rx_entry_t      wdata;
    rx_entry_t      head;

`ifdef UART_RX_CTRL_PERR_DROP_EN
    assign accept_frame = !rx_parity_err_i;
    assign wdata        = '{perr: 1'b0, data: rx_data_i};
    assign rd_perr_o    = 1'b0;
`else
    assign accept_frame = 1'b1;
    assign wdata        = '{perr: rx_parity_err_i, data: rx_data_i};
    assign rd_perr_o    = head.perr;
`endif

    assign rd_data_o = head.data;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state plus push/pop/overrun decisions; a pop in the capture cycle
    // frees a slot, so a full FIFO still accepts the frame
    always_comb begin
        state_d     = state_q;
        pop         = rd_en_i && !empty_o;
        push        = 1'b0;
        overrun_set = 1'b0;
        rx_ack_o    = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_done_i) state_d = CAPTURE;
            end
            CAPTURE: begin
                if (accept_frame) begin
                    if (!full_o || pop) push = 1'b1;
                    else                overrun_set = 1'b1;
                end
                state_d = ACK;
            end
            ACK: begin
                rx_ack_o = 1'b1;
                state_d  = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!rx_done_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sticky overrun; a new overrun beats a clear in the same cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)          overrun_o <= 1'b0;
        else if (overrun_set)  overrun_o <= 1'b1;
        else if (clr_overrun_i) overrun_o <= 1'b0;
    end

    // RTS with one entry of hysteresis below the threshold
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                                rts_n_o <= 1'b0;
        else if (level_o >= LW'(RTS_THRESHOLD))      rts_n_o <= 1'b1;
        else if (level_o <  LW'(RTS_THRESHOLD - 1))  rts_n_o <= 1'b0;
    end

    // Registered interrupt: data waiting or a frame was lost
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) irq_o <= 1'b0;
        else          irq_o <= !empty_o || overrun_o;
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .wdata   (wdata),
        .pop     (pop),
        .rdata   (head),
        .level   (level_o),
        .empty   (empty_o),
        .full    (full_o)
    );

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: a vector table for the main FIFO/flag
// behaviour plus hand-written multi-cycle sequences.
module tb_uart_rx_ctrl;

    localparam int DEPTH = 16;
    localparam int TH    = 12;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          reset_n;
    logic          rx_done_i;
    logic [7:0]    rx_data_i;
    logic          rx_parity_err_i;
    logic          rx_ack_o;
    logic          rd_en_i;
    logic [7:0]    rd_data_o;
    logic          rd_perr_o;
    logic [LW-1:0] level_o;
    logic          empty_o;
    logic          full_o;
    logic          overrun_o;
    logic          clr_overrun_i;
    logic          rts_n_o;
    logic          irq_o;

    uart_rx_ctrl #(
        .FIFO_DEPTH    (DEPTH),
        .RTS_THRESHOLD (TH)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .rx_done_i       (rx_done_i),
        .rx_data_i       (rx_data_i),
        .rx_parity_err_i (rx_parity_err_i),
        .rx_ack_o        (rx_ack_o),
        .rd_en_i         (rd_en_i),
        .rd_data_o       (rd_data_o),
        .rd_perr_o       (rd_perr_o),
        .level_o         (level_o),
        .empty_o         (empty_o),
        .full_o          (full_o),
        .overrun_o       (overrun_o),
        .clr_overrun_i   (clr_overrun_i),
        .rts_n_o         (rts_n_o),
        .irq_o           (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {OP_SEND, OP_POP, OP_CLR} op_e;
    typedef struct {
        op_e        op;
        logic [7:0] data;
        int         lvl;
        logic [7:0] head;
        bit         ovr;
        bit         rts;
    } vec_t;

    vec_t tv[64];
    int   nv;
    int   total;
    int   bad;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input op_e op, input logic [7:0] d, input int lvl,
                                input logic [7:0] head, input bit ovr, input bit rts);
        tv[nv] = '{op: op, data: d, lvl: lvl, head: head, ovr: ovr, rts: rts};
        nv++;
    endfunction

    // Receiver model: raise done, drop it when the ack is seen, count acks
    task automatic send_frame(input logic [7:0] d, input logic pe, input string nm);
        int acks;
        bit seen;
        acks = 0;
        seen = 0;
        rx_data_i       = d;
        rx_parity_err_i = pe;
        rx_done_i       = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (rx_ack_o) begin
                acks++;
                seen = 1;
            end
        end
        rx_done_i       = 1'b0;
        rx_parity_err_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (rx_ack_o) acks++;
        end
        chk({nm, " ack count"}, acks, 1);
    endtask

    task automatic pop_one();
        rd_en_i = 1'b1;
        tick();
        rd_en_i = 1'b0;
        tick();
    endtask

    // Frame whose capture cycle coincides with a host pop
    task automatic push_pop(input logic [7:0] d, input string nm);
        rx_data_i = d;
        rx_done_i = 1'b1;
        tick();              // now in CAPTURE
        rd_en_i = 1'b1;
        tick();              // push and pop on the same edge
        rd_en_i = 1'b0;
        chk({nm, " ack"}, rx_ack_o, 1);
        rx_done_i = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        nv    = 0;
        reset_n         = 1'b0;
        rx_done_i       = 1'b0;
        rx_data_i       = '0;
        rx_parity_err_i = 1'b0;
        rd_en_i         = 1'b0;
        clr_overrun_i   = 1'b0;

        // ---- vector table ----
        add(OP_SEND, 8'h41, 1, 8'h41, 0, 0);
        add(OP_SEND, 8'h42, 2, 8'h41, 0, 0);
        add(OP_SEND, 8'h43, 3, 8'h41, 0, 0);
        add(OP_POP,  8'h00, 2, 8'h42, 0, 0);
        add(OP_POP,  8'h00, 1, 8'h43, 0, 0);
        add(OP_POP,  8'h00, 0, 8'h00, 0, 0);
        add(OP_POP,  8'h00, 0, 8'h00, 0, 0);   // pop while empty
        for (int i = 0; i < 16; i++)
            add(OP_SEND, 8'(8'h10 + i), i + 1, 8'h10, 0, (i + 1) >= TH);
        add(OP_SEND, 8'h99, 16, 8'h10, 1, 1);  // dropped, overrun
        add(OP_CLR,  8'h00, 16, 8'h10, 0, 1);
        for (int k = 1; k <= 16; k++)
            add(OP_POP, 8'h00, 16 - k, 8'(8'h10 + k), 0, (16 - k) >= TH - 1);

        // ---- reset state ----
        #12;
        chk("rst level",   level_o,   0);
        chk("rst empty",   empty_o,   1);
        chk("rst full",    full_o,    0);
        chk("rst overrun", overrun_o, 0);
        chk("rst ack",     rx_ack_o,  0);
        chk("rst rts",     rts_n_o,   0);
        chk("rst irq",     irq_o,     0);
        #10 reset_n = 1'b1;
        tick();

        // ---- apply table ----
        for (int i = 0; i < nv; i++) begin
            case (tv[i].op)
                OP_SEND: send_frame(tv[i].data, 1'b0, $sformatf("v%0d", i));
                OP_POP:  pop_one();
                OP_CLR: begin
                    clr_overrun_i = 1'b1;
                    tick();
                    clr_overrun_i = 1'b0;
                    tick();
                end
                default: ;
            endcase
            chk($sformatf("v%0d level", i),   level_o,   tv[i].lvl);
            chk($sformatf("v%0d empty", i),   empty_o,   tv[i].lvl == 0);
            chk($sformatf("v%0d full", i),    full_o,    tv[i].lvl == DEPTH);
            chk($sformatf("v%0d overrun", i), overrun_o, tv[i].ovr);
            chk($sformatf("v%0d rts_n", i),   rts_n_o,   tv[i].rts);
            chk($sformatf("v%0d irq", i),     irq_o,     (tv[i].lvl != 0) || tv[i].ovr);
            if (tv[i].lvl != 0) begin
                chk($sformatf("v%0d head", i), rd_data_o, tv[i].head);
                chk($sformatf("v%0d perr", i), rd_perr_o, 0);
            end
        end

        // ---- latency: level after 2 clocks, ack in the following cycle ----
        rx_data_i = 8'h5A;
        rx_done_i = 1'b1;
        tick();
        chk("lat level e1", level_o, 0);
        chk("lat ack e1",   rx_ack_o, 0);
        tick();
        chk("lat level e2", level_o, 1);
        chk("lat ack e2",   rx_ack_o, 1);
        rx_done_i = 1'b0;
        tick();
        chk("lat ack e3",   rx_ack_o, 0);
        tick();
        chk("lat head",     rd_data_o, 8'h5A);
        pop_one();

        // ---- done held high for 10 cycles: one push, one ack ----
        begin
            int acks;
            acks = 0;
            rx_data_i = 8'h55;
            rx_done_i = 1'b1;
            for (int i = 0; i < 10; i++) begin
                tick();
                if (rx_ack_o) acks++;
            end
            rx_done_i = 1'b0;
            for (int i = 0; i < 3; i++) begin
                tick();
                if (rx_ack_o) acks++;
            end
            chk("hold acks",  acks, 1);
            chk("hold level", level_o, 1);
            chk("hold head",  rd_data_o, 8'h55);
            pop_one();
        end

        // ---- pop while empty, held several cycles ----
        rd_en_i = 1'b1;
        tick(); tick(); tick();
        rd_en_i = 1'b0;
        tick();
        chk("empty rd level", level_o, 0);
        chk("empty rd empty", empty_o, 1);

        // ---- simultaneous push/pop at level 5 ----
        for (int i = 0; i < 5; i++) send_frame(8'(8'h20 + i), 1'b0, "pp5 fill");
        push_pop(8'h25, "pp5");
        chk("pp5 level", level_o, 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("pp5 head%0d", i), rd_data_o, 8'(8'h21 + i));
            pop_one();
        end

        // ---- simultaneous push/pop at level 16 ----
        for (int i = 0; i < 16; i++) send_frame(8'(8'h30 + i), 1'b0, "pp16 fill");
        push_pop(8'h40, "pp16");
        chk("pp16 level",   level_o,   16);
        chk("pp16 full",    full_o,    1);
        chk("pp16 overrun", overrun_o, 0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("pp16 head%0d", i), rd_data_o, 8'(8'h31 + i));
            pop_one();
        end
        chk("pp16 drained", level_o, 0);

        // ---- parity-error frame ----
        send_frame(8'h7E, 1'b1, "perr");
`ifdef UART_RX_CTRL_PERR_DROP_EN
        chk("perr level", level_o, 0);
`else
        chk("perr level", level_o, 1);
        chk("perr head",  rd_data_o, 8'h7E);
        chk("perr flag",  rd_perr_o, 1);
        pop_one();
`endif

        // ---- reset while in CAPTURE ----
        rx_data_i = 8'hA5;
        rx_done_i = 1'b1;
        tick();               // CAPTURE; push would land on the next edge
        reset_n = 1'b0;
        #1;
        chk("midrst level", level_o, 0);
        chk("midrst empty", empty_o, 1);
        chk("midrst ack",   rx_ack_o, 0);
        rx_done_i = 1'b0;
        #2 reset_n = 1'b1;
        tick(); tick(); tick();
        chk("midrst level after", level_o, 0);
        chk("midrst ack after",   rx_ack_o, 0);
        chk("midrst irq after",   irq_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1);
    end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, meaning: receive FIFO entries; power of two, 4..64.
REQ-002 Parameter RTS_THRESHOLD, default 12, meaning: fill level at or above which rts_n_o is deasserted; 1..FIFO_DEPTH-1.
REQ-003 The port clk SHALL be input, 1 bit: system clock; all state changes on its rising edge.
REQ-004 The port reset_n SHALL be input, 1 bit: asynchronous, active-low reset.
REQ-005 The port rx_done_i SHALL be input, 1 bit: receiver frame-complete level; stays high until acknowledged.
REQ-006 The port rx_data_i SHALL be input, 8 bits: received character, valid while rx_done_i is high.
REQ-007 The port rx_parity_err_i SHALL be input, 1 bit: parity error flag of the current frame.
REQ-008 The port rx_ack_o SHALL be output, 1 bit: one-cycle acknowledge to the receiver; clears its done flag.
REQ-009 The port rd_en_i SHALL be input, 1 bit: host pop request (APB read of data register).
REQ-010 The port rd_data_o SHALL be output, 8 bits: FIFO head character.
REQ-011 The port rd_perr_o SHALL be output, 1 bit: parity flag of the FIFO head.
REQ-012 The port level_o SHALL be output, $clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.
REQ-013 The ports empty_o and full_o SHALL be outputs, 1 bit each: FIFO status.
REQ-014 The port overrun_o SHALL be output, 1 bit: sticky, a frame was dropped because the FIFO was full.
REQ-015 The port clr_overrun_i SHALL be input, 1 bit: one-cycle clear of overrun_o.
REQ-016 The port rts_n_o SHALL be output, 1 bit: flow control to the peripheral; low = ready to receive.
REQ-017 The port irq_o SHALL be output, 1 bit: registered interrupt, high when !empty_o or overrun_o.

Function
REQ-018 The FSM SHALL have states IDLE, CAPTURE, ACK and WAIT_LOW.
REQ-019 IDLE -> CAPTURE SHALL occur on the first cycle rx_done_i is sampled high.
REQ-020 In CAPTURE, if the FIFO is not full, it SHALL push {rx_parity_err_i, rx_data_i} and go to ACK; if full, it SHALL set overrun_o, push nothing and go to ACK.
REQ-021 ACK SHALL assert rx_ack_o for exactly one cycle and then go to WAIT_LOW.
REQ-022 WAIT_LOW SHALL return to IDLE once rx_done_i is low; one frame SHALL yield at most one push.
REQ-023 Latency from rx_done_i rising to level_o increment SHALL be 2 clocks; rx_ack_o SHALL follow in the next cycle.
REQ-024 Pop on rd_en_i SHALL occur only when not empty; rd_en_i while empty SHALL be ignored with no underflow and no level change.
REQ-025 A simultaneous push and pop SHALL leave level_o unchanged and be legal even when full.
REQ-026 rd_data_o/rd_perr_o SHALL show the head combinationally from storage; after a pop the new head SHALL be visible the next cycle.
REQ-027 Pointers SHALL wrap modulo FIFO_DEPTH; level_o SHALL range 0..FIFO_DEPTH.
REQ-028 rts_n_o SHALL be registered: 1 when level >= RTS_THRESHOLD, 0 when level < RTS_THRESHOLD-1 (one-entry hysteresis), otherwise hold.
REQ-029 If clr_overrun_i and a new overrun occur in the same cycle, set SHALL win.

Reset
REQ-030 On reset_n low, the block SHALL asynchronously reset to state IDLE, pointers 0, level_o 0, empty_o 1, full_o 0, overrun_o 0, rx_ack_o 0, rts_n_o 0, irq_o 0.
REQ-031 A reset mid-frame SHALL discard the frame; FIFO contents SHALL be lost, while storage RAM need not be cleared.

Configuration
REQ-032 With UART_RX_CTRL_PERR_DROP_EN defined, frames with rx_parity_err_i=1 SHALL be acknowledged but not pushed, and rd_perr_o SHALL be tied 0.
REQ-033 Without UART_RX_CTRL_PERR_DROP_EN, the parity flag SHALL be stored per entry as in REQ-020.

Structure
REQ-034 Package uart_pkg SHALL hold the rx_ctrl_state_e enum and the default FIFO_DEPTH/RTS_THRESHOLD constants.
REQ-035 Storage and pointers SHALL live in sub-module uart_rx_fifo (synchronous, 9-bit wide, parameterised depth); the FSM, overrun, RTS and IRQ logic SHALL live in uart_rx_ctrl.

Verification
REQ-036 Send 3 frames 0x41,0x42,0x43 -> level_o=3, three single-cycle rx_ack_o pulses, pops return 0x41,0x42,0x43 in order.
REQ-037 Hold rx_done_i high 10 cycles with 0x55 -> exactly one push, one rx_ack_o.
REQ-038 Fill 16 frames, send 0x99 -> full_o=1, overrun_o=1, level_o stays 16; clr_overrun_i clears the flag; pops never return 0x99.
REQ-039 Fill to 12 -> rts_n_o=1; pop to 11 -> still 1; pop to 10 -> rts_n_o=0.
REQ-040 Push and pop in the same cycle at level 16 and at level 5 -> level unchanged, data order preserved; rd_en_i while empty -> no change.
REQ-041 Frame 0x7E with rx_parity_err_i=1: without the macro rd_perr_o=1 at the head; with UART_RX_CTRL_PERR_DROP_EN, level_o stays 0 and rx_ack_o still pulses; reset asserted in CAPTURE -> IDLE, level_o=0.
